// File: rtl/radix8_booth_multiplier.sv
// Pipelined signed N x N radix-8 Booth multiplier with a full 2N-bit registered product.
// Define BOOTH_PIPE_EN to register the partial products before the adder tree (latency 3 instead of 2).
module radix8_booth_multiplier #(
  parameter int N = 16
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N-1:0]   a,
  input  logic [N-1:0]   b,
  output logic [2*N-1:0] Prod
);

  localparam int W = 2 * N;
  localparam int K = (N + 2) / 3;

  logic [N-1:0]   a_r;
  logic [N-1:0]   b_r;
  logic [N+1:0]   a3_r;
  logic [N+1:0]   a3_s;
  logic [3*K:0]   bext_s;
  logic [W-1:0]   a1_ext_s;
  logic [W-1:0]   a3_ext_s;
  logic [W-1:0]   pp_s [K];
  logic [W-1:0]   pp_in_s [K];
  logic [W-1:0]   sum_s;

  // Map one 4-bit recoding window {b[3i+2],b[3i+1],b[3i],b[3i-1]} to its signed multiple of a.
  function automatic logic [W-1:0] booth_sel(
    input logic [3:0]   grp,
    input logic [W-1:0] a1,
    input logic [W-1:0] a3
  );
    logic [W-1:0] mag;
    logic         neg;
    mag = {W{1'b0}};
    neg = 1'b0;
    case (grp)
      4'b0000, 4'b1111: begin mag = {W{1'b0}};          neg = 1'b0; end
      4'b0001, 4'b0010: begin mag = a1;                 neg = 1'b0; end
      4'b0011, 4'b0100: begin mag = {a1[W-2:0], 1'b0};  neg = 1'b0; end
      4'b0101, 4'b0110: begin mag = a3;                 neg = 1'b0; end
      4'b0111:          begin mag = {a1[W-3:0], 2'b00}; neg = 1'b0; end
      4'b1000:          begin mag = {a1[W-3:0], 2'b00}; neg = 1'b1; end
      4'b1001, 4'b1010: begin mag = a3;                 neg = 1'b1; end
      4'b1011, 4'b1100: begin mag = {a1[W-2:0], 1'b0};  neg = 1'b1; end
      4'b1101, 4'b1110: begin mag = a1;                 neg = 1'b1; end
      default:          begin mag = {W{1'b0}};          neg = 1'b0; end
    endcase
    if (neg) begin
      return ~mag + {{(W-1){1'b0}}, 1'b1};
    end else begin
      return mag;
    end
  endfunction

  // The hard multiple 3a is formed before the operand register so stage 2 only selects.
  always_comb begin
    a3_s = {a[N-1], a[N-1], a} + {a[N-1], a, 1'b0};
  end

  // Stage 1: operand capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_r  <= {N{1'b0}};
      b_r  <= {N{1'b0}};
      a3_r <= {(N+2){1'b0}};
    end else begin
      a_r  <= a;
      b_r  <= b;
      a3_r <= a3_s;
    end
  end

  // Sign-extend b to 3K bits and append the implicit b[-1] = 0.
  always_comb begin
    bext_s    = {(3*K+1){1'b0}};
    bext_s[0] = 1'b0;
    for (int j = 0; j < 3*K; j++) begin
      bext_s[j+1] = b_r[(j < N) ? j : (N-1)];
    end
  end

  // Partial products, each already sign-extended to 2N bits and weighted by 8^i.
  always_comb begin
    a1_ext_s = {{(W-N){a_r[N-1]}}, a_r};
    a3_ext_s = {{(W-N-2){a3_r[N+1]}}, a3_r};
    for (int i = 0; i < K; i++) begin
      pp_s[i] = booth_sel(bext_s[3*i +: 4], a1_ext_s, a3_ext_s) << (3*i);
    end
  end

`ifdef BOOTH_PIPE_EN
  logic [W-1:0] pp_r [K];

  // Optional register between partial-product generation and the adder tree.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < K; i++) begin
        pp_r[i] <= {W{1'b0}};
      end
    end else begin
      for (int i = 0; i < K; i++) begin
        pp_r[i] <= pp_s[i];
      end
    end
  end

  // Adder tree input taken from the extra pipeline register.
  always_comb begin
    for (int i = 0; i < K; i++) begin
      pp_in_s[i] = pp_r[i];
    end
  end
`else
  // Adder tree input taken directly from partial-product generation.
  always_comb begin
    for (int i = 0; i < K; i++) begin
      pp_in_s[i] = pp_s[i];
    end
  end
`endif

  // Sum at full 2N-bit width; wrap-around beyond 2N bits is the intended truncation.
  always_comb begin
    sum_s = {W{1'b0}};
    for (int i = 0; i < K; i++) begin
      sum_s = sum_s + pp_in_s[i];
    end
  end

  // Product register.
  always_ff @(posedge clk) begin
    if (rst) begin
      Prod <= {W{1'b0}};
    end else begin
      Prod <= sum_s;
    end
  end

endmodule

// File: tb/tb_radix8_booth_multiplier.sv
// Scoreboard bench for radix8_booth_multiplier; define BOOTH_PIPE_EN to check the 3-clock build.
module tb_radix8_booth_multiplier;

`ifdef BOOTH_PIPE_EN
  localparam int L = 3;
`else
  localparam int L = 2;
`endif

  logic        clk;
  logic        rst;
  logic [15:0] a;
  logic [15:0] b;
  logic [31:0] prod;

  typedef struct {
    logic [31:0] exp;
    int          idx;
  } sb_entry_t;

  sb_entry_t sb_q[$];
  int        checks;
  int        errors;
  int        n_issued;

  radix8_booth_multiplier #(.N(16)) dut (
    .clk  (clk),
    .rst  (rst),
    .a    (a),
    .b    (b),
    .Prod (prod)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%08h) expected %0d (0x%08h)",
               tag, $signed(obs), obs, $signed(exp), exp);
    end
  endtask

  // One clock of stimulus: retire the oldest product, then drive and record the next pair.
  task automatic step(input logic r, input logic [15:0] x, input logic [15:0] y);
    sb_entry_t       e;
    logic signed [31:0] p;
    @(negedge clk);
    if (sb_q.size() == L) begin
      e = sb_q.pop_front();
      check_eq($sformatf("prod#%0d", e.idx), prod, e.exp);
    end
    rst = r;
    a   = x;
    b   = y;
    p   = $signed(x) * $signed(y);
    if (r) begin
      foreach (sb_q[i]) sb_q[i].exp = 32'd0;
    end
    e.exp = r ? 32'd0 : p;
    e.idx = n_issued;
    n_issued++;
    sb_q.push_back(e);
  endtask

  initial begin
    clk      = 1'b0;
    rst      = 1'b1;
    a        = 16'd0;
    b        = 16'd0;
    checks   = 0;
    errors   = 0;
    n_issued = 0;

    // Reset held with live operands, then released.
    step(1'b1, 16'd5, 16'd5);
    step(1'b1, 16'd5, 16'd5);
    for (int i = 0; i < L + 1; i++) step(1'b0, 16'd5, 16'd5);

    // Back-to-back small signed pairs.
    step(1'b0, -16'sd6, 16'sd4);
    step(1'b0, 16'sd7, -16'sd2);
    step(1'b0, -16'sd5, -16'sd3);
    step(1'b0, 16'sd0, 16'sd15);

    // Corner values and extremes.
    step(1'b0, 16'sd127, 16'sd127);
    step(1'b0, -16'sd126, -16'sd1);
    step(1'b0, 16'sd32767, 16'sd32767);
    step(1'b0, 16'h8000, 16'h8000);
    step(1'b0, 16'sd32767, 16'h8000);
    step(1'b0, 16'h8000, 16'sd1);
    step(1'b0, 16'h1234, 16'hFFFF);
    step(1'b0, 16'hABCD, 16'd0);

    // Reset one clock after a pair is applied discards it.
    step(1'b0, 16'd100, 16'd100);
    step(1'b1, 16'd100, 16'd100);
    step(1'b0, 16'd3, 16'd9);
    step(1'b0, 16'd100, 16'd100);
    step(1'b0, 16'd100, 16'd100);
    step(1'b1, 16'd7, 16'd7);
    step(1'b0, 16'd7, 16'd7);

    // Random signed pairs.
    for (int i = 0; i < 10000; i++) begin
      step(1'b0, 16'($urandom), 16'($urandom));
    end

    // Drain the pipeline.
    for (int i = 0; i < L; i++) step(1'b0, 16'd0, 16'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
